stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 117 +++++++++++
 tb/tb_stream_mux_rr.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration and a one-entry output register.
// Optional output-transfer counter port beat_cnt enabled by defining STREAM_MUX_RR_CNT_EN.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
`ifdef STREAM_MUX_RR_CNT_EN
  ,
  output logic [15:0]           beat_cnt
`endif
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_can_load;
  logic              w_grant_vld;
  logic [SEL_W-1:0]  w_grant;
  logic              w_in_xfer;
  logic [WIDTH-1:0]  w_data;
  logic [SEL_W-1:0]  w_ptr_next;
  int                w_idx;

  assign w_can_load = !r_out_valid || out_ready;

  // Grant selection: explicit index in fixed mode, rotating priority from r_ptr in RR mode.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = 0;
    if (mode) begin
      for (int k = 0; k < N_CH; k++) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= N_CH) w_idx = w_idx - N_CH;
        if (!w_grant_vld && in_valid[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant     = w_idx[SEL_W-1:0];
        end
      end
    end else if (int'(sel) < N_CH) begin
      w_grant_vld = 1'b1;
      w_grant     = sel;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready[gi] = w_grant_vld && w_can_load && (int'(w_grant) == gi);
  end

  assign w_in_xfer = |(in_ready & in_valid);

  always_comb begin
    w_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (int'(w_grant) == c) w_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  // Pointer wraps at N_CH, which need not be a power of two.
  always_comb begin
    w_ptr_next = r_ptr;
    if (mode && w_in_xfer) begin
      w_ptr_next = (int'(w_grant) == N_CH - 1) ? '0 : w_grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      r_ptr <= w_ptr_next;
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_ch    <= w_grant;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

`ifdef STREAM_MUX_RR_CNT_EN
  logic [15:0] r_beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (r_out_valid && out_ready) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance (fixed, RR, backpressure, async reset)
// and a 3-channel instance (non-power-of-two wrap, out-of-range select).
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 4-channel instance
  logic        a_rst = 1'b1;
  logic [3:0]  a_in_valid = '0;
  logic [15:0] a_in_data = 16'hDA53;
  logic [3:0]  a_in_ready;
  logic        a_mode = 1'b0;
  logic [1:0]  a_sel = 2'd0;
  logic        a_out_valid;
  logic [3:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_ready = 1'b0;
`ifdef STREAM_MUX_RR_CNT_EN
  logic [15:0] a_cnt;
`endif

  // 3-channel instance
  logic        b_rst = 1'b1;
  logic [2:0]  b_in_valid = '0;
  logic [11:0] b_in_data = 12'h961;
  logic [2:0]  b_in_ready;
  logic        b_mode = 1'b0;
  logic [1:0]  b_sel = 2'd0;
  logic        b_out_valid;
  logic [3:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_ready = 1'b0;
`ifdef STREAM_MUX_RR_CNT_EN
  logic [15:0] b_cnt;
`endif

  stream_mux_rr #(.N_CH(4), .WIDTH(4)) dut4 (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_ready(a_out_ready)
`ifdef STREAM_MUX_RR_CNT_EN
    , .beat_cnt(a_cnt)
`endif
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(4)) dut3 (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready)
`ifdef STREAM_MUX_RR_CNT_EN
    , .beat_cnt(b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs already set; settle, check grant, clock it, check captured beat.
  task automatic beat4(input string tag, input int ch, input logic [3:0] d);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << ch;
    #1 chk({tag, "_rdy"}, 32'(a_in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    chk({tag, "_ov"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_ch"}, 32'(a_out_ch), 32'(ch));
    chk({tag, "_dat"}, 32'(a_out_data), 32'(d));
    $display("dut4 %s: ch=%0d data=%h", tag, a_out_ch, a_out_data);
  endtask

  task automatic beat3(input string tag, input int ch, input logic [3:0] d);
    logic [2:0] exp_rdy;
    exp_rdy = 3'b001 << ch;
    #1 chk({tag, "_rdy"}, 32'(b_in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    chk({tag, "_ov"}, 32'(b_out_valid), 32'd1);
    chk({tag, "_ch"}, 32'(b_out_ch), 32'(ch));
    chk({tag, "_dat"}, 32'(b_out_data), 32'(d));
    $display("dut3 %s: ch=%0d data=%h", tag, b_out_ch, b_out_data);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(a_out_valid), 32'd0);
    chk("rst_dat", 32'(a_out_data), 32'd0);
    chk("rst_ch", 32'(a_out_ch), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Fixed mode: sel=2 then sel=3 (ch3=D, ch2=A, ch1=5, ch0=3)
    a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'hF; a_out_ready = 1'b1;
    beat4("fix_s2", 2, 4'hA);
    a_sel = 2'd3;
    beat4("fix_s3", 3, 4'hD);

    // RR with all valid: pointer starts at 0, fixed mode never moved it
    a_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] dv;
      dv = a_in_data;
      beat4($sformatf("rr_all%0d", i), i % 4, dv[(i % 4)*4 +: 4]);
    end

    // RR with only ch1 and ch3 valid
    a_in_valid = 4'b1010;
    beat4("rr13_0", 1, 4'h5);
    beat4("rr13_1", 3, 4'hD);
    beat4("rr13_2", 1, 4'h5);
    beat4("rr13_3", 3, 4'hD);

    // Backpressure: ch3 beat held, ptr should stay at 0
    a_in_valid = 4'hF; a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_rdy", i), 32'(a_in_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_ov", i), 32'(a_out_valid), 32'd1);
      chk($sformatf("bp%0d_ch", i), 32'(a_out_ch), 32'd3);
      chk($sformatf("bp%0d_dat", i), 32'(a_out_data), 32'hD);
      $display("dut4 bp%0d: ch=%0d data=%h stalled", i, a_out_ch, a_out_data);
    end
    a_out_ready = 1'b1;
    beat4("bp_rel", 0, 4'h3);

    // Drain without new input: out_valid drops, data/ch hold
    a_in_valid = 4'h0;
    #1 chk("drain_rdy", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("drain_ov", 32'(a_out_valid), 32'd0);
    chk("drain_dat", 32'(a_out_data), 32'h3);
    chk("drain_ch", 32'(a_out_ch), 32'd0);
    $display("dut4 drain: out_valid=%0d", a_out_valid);

    // Load ch2 (ptr becomes 3), then async reset mid-cycle with beat held
    a_in_valid = 4'b0100;
    beat4("pre_rst", 2, 4'hA);
    a_out_ready = 1'b0; a_in_valid = 4'hF;
    #2 a_rst = 1'b1;
    #1;
    chk("arst_ov", 32'(a_out_valid), 32'd0);
    chk("arst_dat", 32'(a_out_data), 32'd0);
    chk("arst_ch", 32'(a_out_ch), 32'd0);
    $display("dut4 async reset: out_valid=%0d data=%h ch=%0d", a_out_valid, a_out_data, a_out_ch);
    @(posedge clk); #1;
    a_rst = 1'b0; a_out_ready = 1'b1;
    beat4("post_rst", 0, 4'h3);

    // 3-channel wrap (ch2=9, ch1=6, ch0=1)
    b_mode = 1'b1; b_in_valid = 3'b111; b_out_ready = 1'b1;
    beat3("w3_0", 0, 4'h1);
    beat3("w3_1", 1, 4'h6);
    beat3("w3_2", 2, 4'h9);
    beat3("w3_3", 0, 4'h1);

    // Fixed mode with out-of-range select
    b_mode = 1'b0; b_sel = 2'd3;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("sel3_%0d_rdy", i), 32'(b_in_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("sel3_%0d_ov", i), 32'(b_out_valid), 32'd0);
      $display("dut3 sel3_%0d: out_valid=%0d in_ready=%b", i, b_out_valid, b_in_ready);
    end
`ifdef STREAM_MUX_RR_CNT_EN
    chk("cnt3", 32'(b_cnt), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
